// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   IMM_CLASS      : opcode class (bits [15:13]) marking a two-word instruction
//   fetch_state_t  : assembly FSM states
//   RESET_PC_DEFAULT : default first fetch address after reset
//   is_two_word()  : classifies an opcode word
package fetch_pkg;

    localparam logic [2:0]  IMM_CLASS        = 3'b110;
    localparam logic [15:0] IMM_MASK         = 16'hE000;
    localparam logic [15:0] IMM_MATCH        = {IMM_CLASS, 13'b0_0000_0000_0000};
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } fetch_state_t;

    // True when the opcode word is followed by an immediate word.
    function automatic logic is_two_word(input logic [15:0] word);
        return ((word & IMM_MASK) == IMM_MATCH);
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program counter and request tracker for the fetch stage.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   stall, flush    : hold / redirect requests (flush has priority)
//   redirect_pc     : branch target used when flush=1
//   imem_addr       : word address presented to the instruction memory
//   req_pc          : address of the word arriving on imem_rdata this cycle
//   req_valid       : that arriving word belongs to the current stream
module pc_sequencer
    import fetch_pkg::*;
#(
    parameter int             PC_W     = 32,
    parameter int             ADDR_W   = 21,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [PC_W-1:0]   req_pc,
    output logic              req_valid
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] req_pc_r;
    logic            req_valid_r;
    logic [PC_W-1:0] addr_sel_s;

    // Address mux: redirect beats replay, replay beats sequential fetch.
    always_comb begin
        addr_sel_s = pc_r;
        if (flush) begin
            addr_sel_s = redirect_pc;
        end else if (stall) begin
            addr_sel_s = req_pc_r;
        end else begin
            addr_sel_s = pc_r;
        end
    end

    assign imem_addr = addr_sel_s[ADDR_W-1:0];
    assign req_pc    = req_pc_r;
    assign req_valid = req_valid_r;

    // PC and outstanding-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r        <= RESET_PC;
            req_pc_r    <= RESET_PC;
            req_valid_r <= 1'b0;
        end else if (flush) begin
            pc_r        <= redirect_pc + PC_ONE;
            req_pc_r    <= redirect_pc;
            req_valid_r <= 1'b1;
        end else if (stall) begin
            // The replayed word is re-requested now, so it will be valid
            // next cycle even if the stall landed on the very first fetch.
            pc_r        <= req_pc_r + PC_ONE;
            req_pc_r    <= req_pc_r;
            req_valid_r <= 1'b1;
        end else begin
            pc_r        <= pc_r + PC_ONE;
            req_pc_r    <= pc_r;
            req_valid_r <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word addresses to a synchronous
// instruction memory and assembles one- and two-word instructions.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   imem_addr       : word address (data returns on imem_rdata next cycle)
//   imem_rdata      : word for the previous cycle's address
//   stall           : load-use hold; fd outputs frozen, word replayed
//   flush           : branch taken; drop in-flight work, fetch redirect_pc
//   redirect_pc     : branch target
//   fd_valid        : fd_* describe a complete instruction
//   fd_instr/fd_imm : opcode and immediate (0 for one-word instructions)
//   fd_pc           : opcode address
//   fd_next_pc      : address after the instruction's last word
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 16,
    parameter int              ADDR_W   = 21,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               flush,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               fd_valid,
    output logic [INSTR_W-1:0] fd_instr,
    output logic [INSTR_W-1:0] fd_imm,
    output logic [PC_W-1:0]    fd_pc,
    output logic [PC_W-1:0]    fd_next_pc
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0]    req_pc_s;
    logic               req_valid_s;

    fetch_state_t       state_r,      state_nx_s;
    logic [INSTR_W-1:0] hold_instr_r, hold_instr_nx_s;
    logic [PC_W-1:0]    hold_pc_r,    hold_pc_nx_s;
    logic               fd_valid_r,   fd_valid_nx_s;
    logic [INSTR_W-1:0] fd_instr_r,   fd_instr_nx_s;
    logic [INSTR_W-1:0] fd_imm_r,     fd_imm_nx_s;
    logic [PC_W-1:0]    fd_pc_r,      fd_pc_nx_s;
    logic [PC_W-1:0]    fd_next_pc_r, fd_next_pc_nx_s;

    pc_sequencer #(
        .PC_W     (PC_W),
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_sequencer (
        .clk         (clk),
        .rst_n       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_addr   (imem_addr),
        .req_pc      (req_pc_s),
        .req_valid   (req_valid_s)
    );

    // Assembly FSM: decide what the arriving word contributes this cycle.
    always_comb begin
        state_nx_s      = state_r;
        hold_instr_nx_s = hold_instr_r;
        hold_pc_nx_s    = hold_pc_r;
        fd_valid_nx_s   = fd_valid_r;
        fd_instr_nx_s   = fd_instr_r;
        fd_imm_nx_s     = fd_imm_r;
        fd_pc_nx_s      = fd_pc_r;
        fd_next_pc_nx_s = fd_next_pc_r;

        if (flush) begin
            // Any half-assembled instruction is dropped.
            state_nx_s    = S_OP;
            fd_valid_nx_s = 1'b0;
        end else if (stall) begin
            // Everything frozen; the word will be replayed next cycle.
            state_nx_s = state_r;
        end else if (req_valid_s) begin
            case (state_r)
                S_OP: begin
                    if (is_two_word(imem_rdata)) begin
                        hold_instr_nx_s = imem_rdata;
                        hold_pc_nx_s    = req_pc_s;
                        state_nx_s      = S_IMM;
                        fd_valid_nx_s   = 1'b0;
                    end else begin
                        fd_valid_nx_s   = 1'b1;
                        fd_instr_nx_s   = imem_rdata;
                        fd_imm_nx_s     = {INSTR_W{1'b0}};
                        fd_pc_nx_s      = req_pc_s;
                        fd_next_pc_nx_s = req_pc_s + PC_ONE;
                    end
                end
                S_IMM: begin
                    fd_valid_nx_s   = 1'b1;
                    fd_instr_nx_s   = hold_instr_r;
                    fd_imm_nx_s     = imem_rdata;
                    fd_pc_nx_s      = hold_pc_r;
                    fd_next_pc_nx_s = req_pc_s + PC_ONE;
                    state_nx_s      = S_OP;
                end
                default: begin
                    state_nx_s    = S_OP;
                    fd_valid_nx_s = 1'b0;
                end
            endcase
        end else begin
            fd_valid_nx_s = 1'b0;
        end
    end

    // State, held-opcode and fetch/decode boundary registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= S_OP;
            hold_instr_r <= {INSTR_W{1'b0}};
            hold_pc_r    <= {PC_W{1'b0}};
            fd_valid_r   <= 1'b0;
            fd_instr_r   <= {INSTR_W{1'b0}};
            fd_imm_r     <= {INSTR_W{1'b0}};
            fd_pc_r      <= {PC_W{1'b0}};
            fd_next_pc_r <= {PC_W{1'b0}};
        end else begin
            state_r      <= state_nx_s;
            hold_instr_r <= hold_instr_nx_s;
            hold_pc_r    <= hold_pc_nx_s;
            fd_valid_r   <= fd_valid_nx_s;
            fd_instr_r   <= fd_instr_nx_s;
            fd_imm_r     <= fd_imm_nx_s;
            fd_pc_r      <= fd_pc_nx_s;
            fd_next_pc_r <= fd_next_pc_nx_s;
        end
    end

    assign fd_valid   = fd_valid_r;
    assign fd_instr   = fd_instr_r;
    assign fd_imm     = fd_imm_r;
    assign fd_pc      = fd_pc_r;
    assign fd_next_pc = fd_next_pc_r;

endmodule
